// File: rtl/common.sv
// Shared types and constants for the SAT solve controller and its clause buffer.
package common;

  localparam int number_literal = 3;
  localparam int max_clauses    = 16;

  typedef struct packed {
    logic [number_literal-1:0] pos;
    logic [number_literal-1:0] neg;
  } clause_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORE_RST,
    ST_STREAM,
    ST_SOLVE,
    ST_DONE
  } ctrl_state_t;

endpackage

// File: rtl/clause_buffer.sv
// Clause register file: one synchronous write port, one combinational read port.
module clause_buffer #(
  parameter int W     = 6,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the controller's clause count decides which entries are valid.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sat_solve_controller.sv
// Buffers host clauses, streams them into the SAT core, and captures the verdict with a timeout.
// Optional build macro SAT_CLAUSE_CHECK_EN: drops tautologies, flags empty clauses (empty_clause).
module sat_solve_controller
  import common::*;
#(
  parameter int N_LIT          = number_literal,
  parameter int MAX_CLAUSES    = max_clauses,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CW             = $clog2(MAX_CLAUSES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             h_valid,
  output logic             h_ready,
  input  logic [N_LIT-1:0] h_pos,
  input  logic [N_LIT-1:0] h_neg,
  input  logic             start,
  input  logic             clear,
  output logic             core_reset,
  output logic             core_load,
  output logic [N_LIT-1:0] core_i,
  input  logic             core_ended,
  input  logic             core_sat,
  input  logic [N_LIT-1:0] core_model,
  output logic             busy,
  output logic             done,
  output logic             result_sat,
  output logic [N_LIT-1:0] result_model,
  output logic             timeout,
  output logic             overflow,
`ifdef SAT_CLAUSE_CHECK_EN
  output logic             empty_clause,
`endif
  output logic [CW-1:0]    clause_count
);

  localparam int AW = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CLAUSES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    rd_idx_q, rd_idx_d;
  logic             phase_q, phase_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             res_sat_q, res_sat_d;
  logic [N_LIT-1:0] res_model_q, res_model_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic             empty_q, empty_d;

  logic                 buf_we;
  logic [2*N_LIT-1:0]   buf_rdata;

  clause_buffer #(.W(2 * N_LIT), .DEPTH(MAX_CLAUSES), .AW(AW)) u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (count_q[AW-1:0]),
    .wdata ({h_pos, h_neg}),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    phase_d     = phase_q;
    tmo_d       = tmo_q;
    done_d      = done_q;
    res_sat_d   = res_sat_q;
    res_model_d = res_model_q;
    timeout_d   = timeout_q;
    overflow_d  = overflow_q;
    empty_d     = empty_q;
    h_ready     = 1'b0;
    core_load   = 1'b0;
    core_i      = '0;
    buf_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        h_ready = (count_q < CNT_MAX);
        if (h_valid && (count_q < CNT_MAX)) begin
`ifdef SAT_CLAUSE_CHECK_EN
          if (|(h_pos & h_neg)) begin
            buf_we = 1'b0;
          end else if (~|{h_pos, h_neg}) begin
            empty_d = 1'b1;
          end else begin
            buf_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
`else
          buf_we  = 1'b1;
          count_d = count_q + CW'(1);
`endif
        end else if (h_valid) begin
          overflow_d = 1'b1;
        end
      end
      ST_CORE_RST: begin
        state_d  = ST_STREAM;
        rd_idx_d = '0;
        phase_d  = 1'b0;
      end
      ST_STREAM: begin
        core_load = 1'b1;
        core_i    = phase_q ? buf_rdata[N_LIT-1:0] : buf_rdata[2*N_LIT-1:N_LIT];
        phase_d   = ~phase_q;
        if (phase_q) begin
          if (rd_idx_q == count_q - CW'(1)) begin
            state_d = ST_SOLVE;
            tmo_d   = '0;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      ST_SOLVE: begin
        // A verdict arriving on the last allowed cycle still beats the timeout.
        if (core_ended) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          res_sat_d   = core_sat;
          res_model_d = core_model;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          res_sat_d   = 1'b0;
          res_model_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      if (clear) begin
        state_d     = ST_IDLE;
        count_d     = '0;
        done_d      = 1'b0;
        res_sat_d   = 1'b0;
        res_model_d = '0;
        timeout_d   = 1'b0;
        overflow_d  = 1'b0;
        empty_d     = 1'b0;
      end else if (start) begin
        timeout_d = 1'b0;
        if (empty_q || count_q == '0) begin
          // An empty clause is unsatisfiable; an empty formula is trivially satisfiable.
          state_d     = ST_DONE;
          done_d      = 1'b1;
          res_sat_d   = ~empty_q;
          res_model_d = '0;
        end else begin
          state_d = ST_CORE_RST;
          done_d  = 1'b0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_idx_q    <= '0;
      phase_q     <= 1'b0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      res_sat_q   <= 1'b0;
      res_model_q <= '0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      res_sat_q   <= res_sat_d;
      res_model_q <= res_model_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      empty_q     <= empty_d;
    end
  end

  assign core_reset   = reset | (state_q == ST_CORE_RST);
  assign busy         = (state_q == ST_CORE_RST) || (state_q == ST_STREAM) || (state_q == ST_SOLVE);
  assign done         = done_q;
  assign result_sat   = res_sat_q;
  assign result_model = res_model_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign clause_count = count_q;
`ifdef SAT_CLAUSE_CHECK_EN
  assign empty_clause = empty_q;
`endif

endmodule

// File: tb/tb_sat_solve_controller.sv
// Scoreboard bench for sat_solve_controller: stimulus queues expected core words/results, a monitor compares.
module tb_sat_solve_controller;
  import common::*;

  localparam int NL = 3;
  localparam int MC = 5;
  localparam int TO = 16;
  localparam int CW = $clog2(MC + 1);

  typedef struct {
    logic          sat;
    logic [NL-1:0] model;
    logic          tmo;
    int            lat;
  } res_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          h_valid = 1'b0, h_ready;
  logic [NL-1:0] h_pos = '0, h_neg = '0;
  logic          start = 1'b0, clear = 1'b0;
  logic          core_reset, core_load;
  logic [NL-1:0] core_i;
  logic          core_ended = 1'b0;
  logic          core_sat = 1'b1;
  logic [NL-1:0] core_model = 3'b101;
  logic          busy, done, result_sat, timeout, overflow;
  logic [NL-1:0] result_model;
  logic [CW-1:0] clause_count;
`ifdef SAT_CLAUSE_CHECK_EN
  logic          empty_clause;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [NL-1:0] exp_words[$];
  res_t          exp_res[$];

  logic stub_end = 1'b0;
  logic prev_load = 1'b0, prev_done = 1'b0, prev_in_solve = 1'b0;
  int   rst_cyc = 0;
  int   sc = 0;

  clause_t cl[5] = '{'{3'b110, 3'b000}, '{3'b101, 3'b000}, '{3'b010, 3'b101},
                     '{3'b000, 3'b011}, '{3'b011, 3'b100}};

  sat_solve_controller #(.N_LIT(NL), .MAX_CLAUSES(MC), .TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .h_valid      (h_valid),
    .h_ready      (h_ready),
    .h_pos        (h_pos),
    .h_neg        (h_neg),
    .start        (start),
    .clear        (clear),
    .core_reset   (core_reset),
    .core_load    (core_load),
    .core_i       (core_i),
    .core_ended   (core_ended),
    .core_sat     (core_sat),
    .core_model   (core_model),
    .busy         (busy),
    .done         (done),
    .result_sat   (result_sat),
    .result_model (result_model),
    .timeout      (timeout),
    .overflow     (overflow),
`ifdef SAT_CLAUSE_CHECK_EN
    .empty_clause (empty_clause),
`endif
    .clause_count (clause_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [NL-1:0] p, input logic [NL-1:0] n);
    h_valid = 1'b1;
    h_pos   = p;
    h_neg   = n;
    @(negedge clock);
    h_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  // Monitor and stub core: samples on the falling edge, drives core_ended for the next rising edge.
  always @(negedge clock) begin
    logic in_solve;
    res_t r;
    in_solve = busy && !core_load && !core_reset;
    if (core_reset && !reset && !core_load) rst_cyc++;
    if (core_load) begin
      if (!prev_load) begin
        check("core_reset_cycles", rst_cyc, 1);
        rst_cyc = 0;
      end
      if (exp_words.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_core_load: core_i=%0b, no word expected", core_i);
      end else begin
        check("core_i", {29'd0, core_i}, {29'd0, exp_words.pop_front()});
      end
    end
    if (prev_load && !core_load) begin
      check("stream_words_left", exp_words.size(), 0);
      check("core_i_after_stream", {29'd0, core_i}, 32'd0);
    end
    if (in_solve) sc = prev_in_solve ? sc + 1 : 0;
    if (done && !prev_done) begin
      if (exp_res.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: result_sat=%0b, no result expected", result_sat);
      end else begin
        r = exp_res.pop_front();
        check("result_sat", {31'd0, result_sat}, {31'd0, r.sat});
        check("result_model", {29'd0, result_model}, {29'd0, r.model});
        check("timeout_flag", {31'd0, timeout}, {31'd0, r.tmo});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (r.lat >= 0) check("solve_latency", sc + 1, r.lat);
      end
    end
    core_ended    = stub_end && in_solve && (sc == 7);
    prev_load     = core_load;
    prev_done     = done;
    prev_in_solve = in_solve;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    check("core_reset_during_reset", {31'd0, core_reset}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_h_ready", {31'd0, h_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd0);
    check("rst_core_load", {31'd0, core_load}, 32'd0);
    check("rst_clause_count", clause_count, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_result", {28'd0, result_sat, result_model}, 32'd0);

    // Five clauses, core answers SAT with model 101 eight cycles after entering SOLVE.
    for (int i = 0; i < 5; i++) push(cl[i].pos, cl[i].neg);
    check("count_after_load", clause_count, 32'd5);
    check("h_ready_full", {31'd0, h_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      exp_words.push_back(cl[i].pos);
      exp_words.push_back(cl[i].neg);
    end
    exp_res.push_back('{sat: 1'b1, model: 3'b101, tmo: 1'b0, lat: 8});
    stub_end = 1'b1;
    pulse_start();
    wait_done();
    @(negedge clock);
    check("h_ready_in_done", {31'd0, h_ready}, 32'd0);
    check("done_held", {31'd0, done}, 32'd1);

    // Replay of the same formula; core never ends, so the run times out.
    for (int i = 0; i < 5; i++) begin
      exp_words.push_back(cl[i].pos);
      exp_words.push_back(cl[i].neg);
    end
    exp_res.push_back('{sat: 1'b0, model: 3'b000, tmo: 1'b1, lat: TO});
    stub_end = 1'b0;
    pulse_start();
    wait_done();
    @(negedge clock);
    check("timeout_sticky", {31'd0, timeout}, 32'd1);

    // Clear, then overfill the buffer.
    pulse_clear();
    check("clear_count", clause_count, 32'd0);
    check("clear_done", {31'd0, done}, 32'd0);
    check("clear_timeout", {31'd0, timeout}, 32'd0);
    for (int i = 0; i < 6; i++) push(cl[i % 5].pos, cl[i % 5].neg);
    check("overflow_count", clause_count, 32'd5);
    check("overflow_flag", {31'd0, overflow}, 32'd1);
    check("overflow_h_ready", {31'd0, h_ready}, 32'd0);
    pulse_clear();
    check("clear2_count", clause_count, 32'd0);
    check("clear2_overflow", {31'd0, overflow}, 32'd0);
    check("clear2_h_ready", {31'd0, h_ready}, 32'd1);

    // Empty formula: satisfiable immediately, core never loaded.
    exp_res.push_back('{sat: 1'b1, model: 3'b000, tmo: 1'b0, lat: -1});
    pulse_start();
    check("empty_start_done", {31'd0, done}, 32'd1);
    check("empty_start_sat", {31'd0, result_sat}, 32'd1);

`ifdef SAT_CLAUSE_CHECK_EN
    pulse_clear();
    push(3'b011, 3'b010);
    check("tautology_count", clause_count, 32'd0);
    push(3'b000, 3'b000);
    check("empty_clause_flag", {31'd0, empty_clause}, 32'd1);
    check("empty_clause_count", clause_count, 32'd0);
    exp_res.push_back('{sat: 1'b0, model: 3'b000, tmo: 1'b0, lat: -1});
    pulse_start();
    check("unsat_start_done", {31'd0, done}, 32'd1);
    check("unsat_start_sat", {31'd0, result_sat}, 32'd0);
    check("unsat_no_core_reset", rst_cyc, 32'd0);
`endif

    repeat (3) @(negedge clock);
    check("results_left", exp_res.size(), 0);
    check("words_left", exp_words.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sat_solve_controller.md
Name: sat_solve_controller

Overview:
- Sequences one solve run of the SAT solver core.
- Accepts clauses from a host over a valid/ready handshake and buffers them.
- On `start`: resets the core, streams the buffered clauses into the core's load interface (positive-literal word, then negated-literal word per clause), and waits for the core's `ended`.
- Captures `sat`/`model` into host-visible result registers, with a solve timeout.

Parameters:
- N_LIT, default number_literal (package common): literals per clause word.
- MAX_CLAUSES, default 16: clause buffer depth.
- TIMEOUT_CYCLES, default 4096: maximum SOLVE-state cycles before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- h_valid  in  1  host clause valid
- h_ready  out  1  controller can accept a clause
- h_pos  in  N_LIT  positive-literal mask (bit set = literal appears uncomplemented)
- h_neg  in  N_LIT  negated-literal mask
- start  in  1  one-cycle pulse: run solve on the buffered clauses
- clear  in  1  one-cycle pulse: empty the buffer and clear results/flags
- core_reset  out  1  reset to solver core
- core_load  out  1  load strobe to solver core
- core_i  out  N_LIT  clause word to solver core
- core_ended  in  1  core finished
- core_sat  in  1  core verdict
- core_model  in  N_LIT  core satisfying assignment
- busy  out  1  state is CORE_RST, STREAM or SOLVE
- done  out  1  result valid (level)
- result_sat  out  1  captured verdict
- result_model  out  N_LIT  captured model
- timeout  out  1  sticky: run aborted on timeout
- overflow  out  1  sticky: h_valid seen while buffer full
- clause_count  out  $clog2(MAX_CLAUSES+1)  clauses buffered

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; count=0; all outputs 0 except `h_ready`=1.
  - `core_reset` = reset OR (state==CORE_RST), combinational.
- FSM states: IDLE, CORE_RST, STREAM, SOLVE, DONE.
- IDLE:
  - `h_ready` = (count < MAX_CLAUSES).
  - On h_valid&&h_ready, write {h_pos,h_neg} at index count; count++ next cycle.
  - h_valid while full: clause dropped, `overflow` set.
- Leaving IDLE/DONE (`start` and `clear` are honoured only in IDLE or DONE; `clear` wins over `start`):
  - `start` with count==0 → DONE next cycle, result_sat=1, result_model=0 (empty formula is satisfiable).
  - `start` with count>0 → CORE_RST, and done/timeout clear.
  - `clear` → IDLE; count=0; done, result_*, timeout and overflow clear.
- CORE_RST: exactly 1 cycle with `core_reset`=1, then STREAM.
- STREAM:
  - Lasts exactly 2*count cycles with `core_load`=1.
  - Even cycle 2k: core_i = pos[k]. Odd cycle 2k+1: core_i = neg[k].
  - Then SOLVE, with core_load=0 and core_i=0.
- SOLVE:
  - Cycle counter starts at 0.
  - `core_ended`=1 → capture core_sat/core_model into result_*, go to DONE.
  - Counter == TIMEOUT_CYCLES-1 without `core_ended` → timeout=1, result_sat=0, result_model=0, go to DONE.
  - `core_ended` on the same cycle as timeout → `core_ended` wins.
- DONE:
  - `done`=1 held; h_ready=0.
  - Buffer retained, so `start` re-runs the same formula.
- h_ready=0 in every state other than IDLE. `start`/`clear` are ignored while busy.
- Reset mid-run: immediate return to IDLE, buffer emptied; `core_reset` asserted through reset.

Optional Feature:
- Macro: SAT_CLAUSE_CHECK_EN.
- With it defined:
  - At accept time a clause with (h_pos & h_neg) != 0 is a tautology: handshake completes, clause is dropped, count unchanged.
  - A clause with h_pos==0 and h_neg==0 is empty: it is dropped and sticky `empty_clause` (extra 1-bit output) is set. `clear` clears it.
  - `start` with empty_clause=1 → DONE next cycle with result_sat=0, result_model=0; the core is not run.
- Without it: every accepted clause is stored; the `empty_clause` port does not exist.

Decomposition:
- Package common gains:
  - max_clauses constant;
  - clause_t packed struct {pos, neg} of number_literal bits each;
  - ctrl_state_t enum of the five states.
- Sub-module clause_buffer: MAX_CLAUSES-entry clause_t register file with a write port (we, waddr, wdata) and a combinational read port (raddr → rdata). The controller holds the FSM, pointers and counters.

Test Plan:
- N_LIT=3: load (110,000),(101,000),(010,101),(000,011),(011,100), then pulse `start` → 1 cycle core_reset; core_load high exactly 10 cycles; core_i = 110,000,101,000,010,101,000,011,011,100; then core_load=0.
- Stub core raises core_ended 7 cycles into SOLVE with sat=1, model=101 → done=1, result_sat=1, result_model=101, busy=0; a second `start` replays the identical 10-word stream.
- Stub core never ends, TIMEOUT_CYCLES=16 → done exactly 16 cycles after SOLVE entry; timeout=1; result_sat=0.
- MAX_CLAUSES=4, push 5 clauses → h_ready=0 after the 4th, overflow=1, clause_count=4; `clear` → clause_count=0, overflow=0.
- `start` with an empty buffer → done the next cycle, result_sat=1, result_model=000, core_load never asserted.
- SAT_CLAUSE_CHECK_EN: push (011,010) → count unchanged; push (000,000) → empty_clause=1; `start` → done with result_sat=0, no core_reset/core_load activity.
